// File: rtl/axi_wr_arbiter.sv
// Write-channel arbiter: shares one slave AW/W/B port among NUM_M masters.
// Round-robin grant on AW; the grant is held through the W burst and the B
// response, so exactly one write transaction is in flight at a time.
module axi_wr_arbiter #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned IDW   = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // Master-side AW
    input  logic [NUM_M*IDW-1:0]       m_awid_i,
    input  logic [NUM_M*AW-1:0]        m_awaddr_i,
    input  logic [NUM_M*4-1:0]         m_awlen_i,
    input  logic [NUM_M*3-1:0]         m_awsize_i,
    input  logic [NUM_M*2-1:0]         m_awburst_i,
    input  logic [NUM_M-1:0]           m_awvalid_i,
    output logic [NUM_M-1:0]           m_awready_o,
    // Master-side W
    input  logic [NUM_M*IDW-1:0]       m_wid_i,
    input  logic [NUM_M*DW-1:0]        m_wdata_i,
    input  logic [NUM_M*(DW/8)-1:0]    m_wstrb_i,
    input  logic [NUM_M-1:0]           m_wlast_i,
    input  logic [NUM_M-1:0]           m_wvalid_i,
    output logic [NUM_M-1:0]           m_wready_o,
    // Master-side B
    output logic [IDW-1:0]             m_bid_o,
    output logic [1:0]                 m_bresp_o,
    output logic [NUM_M-1:0]           m_bvalid_o,
    input  logic [NUM_M-1:0]           m_bready_i,
    // Slave-side AW
    output logic [IDW-1:0]             s_awid_o,
    output logic [AW-1:0]              s_awaddr_o,
    output logic [3:0]                 s_awlen_o,
    output logic [2:0]                 s_awsize_o,
    output logic [1:0]                 s_awburst_o,
    output logic                       s_awvalid_o,
    input  logic                       s_awready_i,
    // Slave-side W
    output logic [IDW-1:0]             s_wid_o,
    output logic [DW-1:0]              s_wdata_o,
    output logic [DW/8-1:0]            s_wstrb_o,
    output logic                       s_wlast_o,
    output logic                       s_wvalid_o,
    input  logic                       s_wready_i,
    // Slave-side B
    input  logic [IDW-1:0]             s_bid_i,
    input  logic [1:0]                 s_bresp_i,
    input  logic                       s_bvalid_i,
    output logic                       s_bready_o,
    // Status
    output logic [$clog2(NUM_M)-1:0]   gnt_idx_o,
    output logic                       busy_o,
    output logic                       proto_err_o
);

    localparam int unsigned GW = $clog2(NUM_M);
    localparam int unsigned SW = DW / 8;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] last_q, last_d;
    logic [3:0]    beat_q, beat_d;
    logic [3:0]    len_q, len_d;
    logic          proto_err_q, proto_err_d;

    logic [GW-1:0] rr_cand;
    logic [GW-1:0] rr_idx;
    logic          rr_found;
    logic          last_beat;

    // Round-robin pick: first requester after last_q, wrapping modulo NUM_M
    always_comb begin
        rr_cand  = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int unsigned i = 1; i <= NUM_M; i++) begin
            rr_cand = GW'((32'(last_q) + i) % NUM_M);
            if (!rr_found && m_awvalid_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    assign last_beat = (beat_q == len_q);

    // Payload muxes follow the held grant; only valid/ready are state-gated
    always_comb begin
        s_awid_o    = m_awid_i[gnt_q*IDW +: IDW];
        s_awaddr_o  = m_awaddr_i[gnt_q*AW +: AW];
        s_awlen_o   = m_awlen_i[gnt_q*4 +: 4];
        s_awsize_o  = m_awsize_i[gnt_q*3 +: 3];
        s_awburst_o = m_awburst_i[gnt_q*2 +: 2];
        s_wid_o     = m_wid_i[gnt_q*IDW +: IDW];
        s_wdata_o   = m_wdata_i[gnt_q*DW +: DW];
        s_wstrb_o   = m_wstrb_i[gnt_q*SW +: SW];
        m_bid_o     = s_bid_i;
        m_bresp_o   = s_bresp_i;
    end

    // Next-state and handshake routing for the IDLE->ADDR->DATA->RESP cycle
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        beat_d      = beat_q;
        len_d       = len_q;
        proto_err_d = 1'b0;
        m_awready_o = '0;
        m_wready_o  = '0;
        m_bvalid_o  = '0;
        s_awvalid_o = 1'b0;
        s_wvalid_o  = 1'b0;
        s_wlast_o   = 1'b0;
        s_bready_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    gnt_d   = rr_idx;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                s_awvalid_o         = m_awvalid_i[gnt_q];
                m_awready_o[gnt_q]  = s_awready_i;
                if (s_awvalid_o && s_awready_i) begin
                    len_d   = m_awlen_i[gnt_q*4 +: 4];
                    beat_d  = '0;
                    state_d = StData;
                end
            end
            StData: begin
                s_wvalid_o         = m_wvalid_i[gnt_q];
                s_wlast_o          = last_beat;
                m_wready_o[gnt_q]  = s_wready_i;
                if (s_wvalid_o && s_wready_i) begin
                    beat_d      = beat_q + 4'd1;
                    proto_err_d = (m_wlast_i[gnt_q] != last_beat);
                    // Burst length is owned by awlen; master wlast is only audited
                    if (last_beat) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                m_bvalid_o[gnt_q] = s_bvalid_i;
                s_bready_o        = m_bready_i[gnt_q];
                if (s_bvalid_i && s_bready_o) begin
                    last_d  = gnt_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            last_q      <= GW'(NUM_M - 1);
            beat_q      <= '0;
            len_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign gnt_idx_o   = gnt_q;
    assign busy_o      = (state_q != StIdle);
    assign proto_err_o = proto_err_q;

endmodule
